// File: rtl/ysyx_22040210_rf_scoreboard_if.sv
// ---------------------------------------------------------------------------
// ysyx_22040210_rf_scoreboard_if
// Purpose : bundles the three handshake channels of the register-file
//           scoreboard: instruction issue, fast writeback (wb0) and slow
//           writeback (wb1).
// Signals : issue_*  - issue request with source/destination operands,
//                      issue_ready_o returned by the scoreboard
//           wb0_*    - fast writeback (ALU-class results)
//           wb1_*    - slow writeback (long-latency LSU/MDU results)
// Modports: master - the pipeline side that drives requests
//           slave  - the scoreboard side that returns the ready signals
// ---------------------------------------------------------------------------
interface ysyx_22040210_rf_scoreboard_if;

   logic        issue_valid_i;
   logic        issue_ready_o;
   logic        issue_re1_i;
   logic        issue_re2_i;
   logic [4:0]  issue_rs1_i;
   logic [4:0]  issue_rs2_i;
   logic        issue_we_i;
   logic [4:0]  issue_rd_i;
   logic        issue_long_i;

   logic        wb0_valid_i;
   logic        wb0_ready_o;
   logic [4:0]  wb0_addr_i;
   logic [63:0] wb0_data_i;

   logic        wb1_valid_i;
   logic        wb1_ready_o;
   logic [4:0]  wb1_addr_i;
   logic [63:0] wb1_data_i;

   modport master (
      output issue_valid_i, issue_re1_i, issue_re2_i, issue_rs1_i,
             issue_rs2_i, issue_we_i, issue_rd_i, issue_long_i,
      input  issue_ready_o,
      output wb0_valid_i, wb0_addr_i, wb0_data_i,
      input  wb0_ready_o,
      output wb1_valid_i, wb1_addr_i, wb1_data_i,
      input  wb1_ready_o
   );

   modport slave (
      input  issue_valid_i, issue_re1_i, issue_re2_i, issue_rs1_i,
             issue_rs2_i, issue_we_i, issue_rd_i, issue_long_i,
      output issue_ready_o,
      input  wb0_valid_i, wb0_addr_i, wb0_data_i,
      output wb0_ready_o,
      input  wb1_valid_i, wb1_addr_i, wb1_data_i,
      output wb1_ready_o
   );

endinterface

// File: rtl/ysyx_22040210_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// ysyx_22040210_rf_scoreboard
// Purpose : tracks registers with an outstanding long-latency write, stalls
//           issue on RAW/WAW hazards against them, and arbitrates the two
//           writeback channels onto a single regfile write port. The fast
//           channel normally wins; the slow channel is promoted for one
//           grant after it has waited STARVE_LIMIT consecutive cycles.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           sb_if (slave) - issue / wb0 / wb1 handshakes
//           we_o, waddr_o, wdata_o - combinational regfile write port
//           busy_o        - registered pending-write bitmap (bit 0 always 0)
//           busy_cnt_o    - popcount of busy_o
// ---------------------------------------------------------------------------
module ysyx_22040210_rf_scoreboard #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   ysyx_22040210_rf_scoreboard_if.slave      sb_if,
   output logic                              we_o,
   output logic [4:0]                        waddr_o,
   output logic [63:0]                       wdata_o,
   output logic [31:0]                       busy_o,
   output logic [5:0]                        busy_cnt_o
);

   typedef enum logic {
      ARB_NORM,
      ARB_SLOW
   } arb_state_e;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   arb_state_e  arb_state_q, arb_state_d;
   logic [2:0]  starve_cnt_q, starve_cnt_d;
   logic [31:0] busy_q, busy_d;

   logic        issue_ready;
   logic        issue_fire;
   logic        hazard;
   logic        wb0_ready, wb1_ready;
   logic        wb0_fire, wb1_fire;
   logic [5:0]  busy_cnt;

   // Hazard detection looks only at the registered busy bits, so a register
   // being cleared by wb1 this cycle still stalls a dependent issue until
   // the next cycle. Ready is forced low while in reset.
   always_comb begin
      hazard = (sb_if.issue_re1_i & (sb_if.issue_rs1_i != 5'd0) & busy_q[sb_if.issue_rs1_i])
             | (sb_if.issue_re2_i & (sb_if.issue_rs2_i != 5'd0) & busy_q[sb_if.issue_rs2_i])
             | (sb_if.issue_we_i  & (sb_if.issue_rd_i  != 5'd0) & busy_q[sb_if.issue_rd_i]);
      issue_ready = ~rst & ~hazard;
      issue_fire  = sb_if.issue_valid_i & issue_ready;
   end

   // Writeback arbiter. The favoured channel is always ready; the other is
   // ready only when the favoured one is idle, so at most one fires per
   // cycle. The starve counter measures how long wb1 has been held off and
   // promotes it to SLOW once it reaches the limit; SLOW lasts until wb1
   // either gets its grant or withdraws.
   always_comb begin
      arb_state_d  = arb_state_q;
      starve_cnt_d = starve_cnt_q;
      wb0_ready    = 1'b0;
      wb1_ready    = 1'b0;

      if (!rst) begin
         case (arb_state_q)
            ARB_NORM: begin
               wb0_ready = 1'b1;
               wb1_ready = ~sb_if.wb0_valid_i;
            end
            ARB_SLOW: begin
               wb1_ready = 1'b1;
               wb0_ready = ~sb_if.wb1_valid_i;
            end
            default: begin
               wb0_ready = 1'b0;
               wb1_ready = 1'b0;
            end
         endcase
      end

      wb0_fire = sb_if.wb0_valid_i & wb0_ready;
      wb1_fire = sb_if.wb1_valid_i & wb1_ready;

      if (sb_if.wb1_valid_i & ~wb1_ready) begin
         if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
         end
      end else begin
         starve_cnt_d = 3'd0;
      end

      case (arb_state_q)
         ARB_NORM: if (starve_cnt_d == LIMIT) arb_state_d = ARB_SLOW;
         ARB_SLOW: if (wb1_fire | ~sb_if.wb1_valid_i) arb_state_d = ARB_NORM;
         default:  arb_state_d = ARB_NORM;
      endcase
   end

   // Busy bitmap update: the clear from a slow writeback is applied first so
   // that a new long issue to the same register in the same cycle wins.
   always_comb begin
      busy_d = busy_q;
      if (wb1_fire) begin
         busy_d[sb_if.wb1_addr_i] = 1'b0;
      end
      if (issue_fire & sb_if.issue_we_i & sb_if.issue_long_i & (sb_if.issue_rd_i != 5'd0)) begin
         busy_d[sb_if.issue_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Regfile write port mirrors whichever channel fired; x0 writes complete
   // the handshake but never raise we_o.
   always_comb begin
      we_o    = (wb0_fire & (sb_if.wb0_addr_i != 5'd0))
              | (wb1_fire & (sb_if.wb1_addr_i != 5'd0));
      waddr_o = 5'd0;
      wdata_o = 64'd0;
      if (wb0_fire) begin
         waddr_o = sb_if.wb0_addr_i;
         wdata_o = sb_if.wb0_data_i;
      end else if (wb1_fire) begin
         waddr_o = sb_if.wb1_addr_i;
         wdata_o = sb_if.wb1_data_i;
      end
   end

   // Population count of the registered bitmap.
   always_comb begin
      busy_cnt = 6'd0;
      for (int i = 0; i < 32; i++) begin
         busy_cnt = busy_cnt + 6'(busy_q[i]);
      end
   end

   // State registers; reset drops every pending bit and returns to NORM.
   always_ff @(posedge clk) begin
      if (rst) begin
         arb_state_q  <= ARB_NORM;
         starve_cnt_q <= 3'd0;
         busy_q       <= 32'd0;
      end else begin
         arb_state_q  <= arb_state_d;
         starve_cnt_q <= starve_cnt_d;
         busy_q       <= busy_d;
      end
   end

   assign sb_if.issue_ready_o = issue_ready;
   assign sb_if.wb0_ready_o   = wb0_ready;
   assign sb_if.wb1_ready_o   = wb1_ready;
   assign busy_o              = busy_q;
   assign busy_cnt_o          = busy_cnt;

endmodule

// File: tb/tb_ysyx_22040210_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040210_rf_scoreboard
// Purpose : directed self-checking bench for the register-file scoreboard.
//           Inputs change 1 time unit after a rising edge; combinational
//           outputs are sampled 1 unit later, registered outputs likewise,
//           always well away from the next rising edge.
// ---------------------------------------------------------------------------
module tb_ysyx_22040210_rf_scoreboard;

   logic        clk;
   logic        rst;
   logic        we_o;
   logic [4:0]  waddr_o;
   logic [63:0] wdata_o;
   logic [31:0] busy_o;
   logic [5:0]  busy_cnt_o;

   int checks = 0;
   int errors = 0;

   ysyx_22040210_rf_scoreboard_if sb_if ();

   ysyx_22040210_rf_scoreboard #(
      .STARVE_LIMIT(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sb_if      (sb_if),
      .we_o       (we_o),
      .waddr_o    (waddr_o),
      .wdata_o    (wdata_o),
      .busy_o     (busy_o),
      .busy_cnt_o (busy_cnt_o)
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Return every request input to idle.
   task automatic idle_inputs();
      sb_if.issue_valid_i = 1'b0;
      sb_if.issue_re1_i   = 1'b0;
      sb_if.issue_re2_i   = 1'b0;
      sb_if.issue_rs1_i   = 5'd0;
      sb_if.issue_rs2_i   = 5'd0;
      sb_if.issue_we_i    = 1'b0;
      sb_if.issue_rd_i    = 5'd0;
      sb_if.issue_long_i  = 1'b0;
      sb_if.wb0_valid_i   = 1'b0;
      sb_if.wb0_addr_i    = 5'd0;
      sb_if.wb0_data_i    = 64'd0;
      sb_if.wb1_valid_i   = 1'b0;
      sb_if.wb1_addr_i    = 5'd0;
      sb_if.wb1_data_i    = 64'd0;
   endtask

   // Drive a long-latency issue writing rd.
   task automatic drive_long_issue(input logic [4:0] rd);
      sb_if.issue_valid_i = 1'b1;
      sb_if.issue_we_i    = 1'b1;
      sb_if.issue_long_i  = 1'b1;
      sb_if.issue_rd_i    = rd;
   endtask

   // Outputs forced low during reset, then clean state after release.
   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      sb_if.issue_valid_i = 1'b1;
      sb_if.wb0_valid_i   = 1'b1;
      sb_if.wb0_addr_i    = 5'd3;
      sb_if.wb0_data_i    = 64'h5;
      tick();
      #1;
      checks++; if (sb_if.issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_issue_ready got %0b exp 0", sb_if.issue_ready_o); end
      checks++; if (sb_if.wb0_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb0_ready got %0b exp 0", sb_if.wb0_ready_o); end
      checks++; if (sb_if.wb1_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb1_ready got %0b exp 0", sb_if.wb1_ready_o); end
      checks++; if (we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %0b exp 0", we_o); end
      checks++; if (waddr_o !== 5'd0 || wdata_o !== 64'd0) begin errors++; $display("[TB] FAIL reset_wport got %0h/%0h exp 0/0", waddr_o, wdata_o); end
      checks++; if (busy_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_busy got %0h exp 0", busy_o); end
      rst = 1'b0;
      idle_inputs();
      #1;
      checks++; if (sb_if.issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready got %0b exp 1", sb_if.issue_ready_o); end
      checks++; if (busy_cnt_o !== 6'd0) begin errors++; $display("[TB] FAIL post_reset_cnt got %0d exp 0", busy_cnt_o); end
      tick();
   endtask

   // Long issue to x5 then RAW/WAW stalls until wb1 returns x5.
   task automatic test_raw_hazard();
      drive_long_issue(5'd5);
      #1;
      checks++; if (sb_if.issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL raw_issue_ready got %0b exp 1", sb_if.issue_ready_o); end
      tick();
      idle_inputs();
      #1;
      checks++; if (busy_o !== 32'h0000_0020) begin errors++; $display("[TB] FAIL raw_busy_set got %0h exp 20", busy_o); end
      checks++; if (busy_cnt_o !== 6'd1) begin errors++; $display("[TB] FAIL raw_busy_cnt got %0d exp 1", busy_cnt_o); end
      sb_if.issue_valid_i = 1'b1;
      sb_if.issue_re1_i   = 1'b1;
      sb_if.issue_rs1_i   = 5'd5;
      #1;
      checks++; if (sb_if.issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL raw_rs1_stall got %0b exp 0", sb_if.issue_ready_o); end
      sb_if.issue_re1_i = 1'b0;
      sb_if.issue_re2_i = 1'b1;
      sb_if.issue_rs2_i = 5'd5;
      #1;
      checks++; if (sb_if.issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL raw_rs2_stall got %0b exp 0", sb_if.issue_ready_o); end
      sb_if.issue_re2_i = 1'b0;
      sb_if.issue_we_i  = 1'b1;
      sb_if.issue_rd_i  = 5'd5;
      #1;
      checks++; if (sb_if.issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL waw_stall got %0b exp 0", sb_if.issue_ready_o); end
      sb_if.issue_we_i  = 1'b0;
      sb_if.issue_rd_i  = 5'd0;
      sb_if.issue_re1_i = 1'b1;
      tick();
      checks++; if (sb_if.issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL raw_still_stall got %0b exp 0", sb_if.issue_ready_o); end
      sb_if.wb1_valid_i = 1'b1;
      sb_if.wb1_addr_i  = 5'd5;
      sb_if.wb1_data_i  = 64'hAA;
      #1;
      checks++; if (sb_if.issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL raw_no_bypass got %0b exp 0", sb_if.issue_ready_o); end
      checks++; if (sb_if.wb1_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL raw_wb1_ready got %0b exp 1", sb_if.wb1_ready_o); end
      checks++; if (we_o !== 1'b1 || waddr_o !== 5'd5 || wdata_o !== 64'hAA) begin errors++; $display("[TB] FAIL raw_wb1_write got %0b/%0d/%0h exp 1/5/aa", we_o, waddr_o, wdata_o); end
      tick();
      sb_if.wb1_valid_i = 1'b0;
      #1;
      checks++; if (busy_o !== 32'd0) begin errors++; $display("[TB] FAIL raw_busy_clear got %0h exp 0", busy_o); end
      checks++; if (sb_if.issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL raw_release got %0b exp 1", sb_if.issue_ready_o); end
      idle_inputs();
      tick();
   endtask

   // Both writebacks valid in NORM: wb0 wins.
   task automatic test_wb_priority();
      sb_if.wb0_valid_i = 1'b1;
      sb_if.wb0_addr_i  = 5'd3;
      sb_if.wb0_data_i  = 64'h33;
      sb_if.wb1_valid_i = 1'b1;
      sb_if.wb1_addr_i  = 5'd7;
      sb_if.wb1_data_i  = 64'h77;
      #1;
      checks++; if (we_o !== 1'b1 || waddr_o !== 5'd3 || wdata_o !== 64'h33) begin errors++; $display("[TB] FAIL prio_write got %0b/%0d/%0h exp 1/3/33", we_o, waddr_o, wdata_o); end
      checks++; if (sb_if.wb0_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL prio_wb0_ready got %0b exp 1", sb_if.wb0_ready_o); end
      checks++; if (sb_if.wb1_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL prio_wb1_ready got %0b exp 0", sb_if.wb1_ready_o); end
      tick();
      idle_inputs();
      tick();
   endtask

   // wb1 starved for 4 cycles, then granted once in SLOW, then NORM again.
   task automatic test_starve();
      sb_if.wb0_valid_i = 1'b1;
      sb_if.wb0_addr_i  = 5'd1;
      sb_if.wb0_data_i  = 64'h1;
      sb_if.wb1_valid_i = 1'b1;
      sb_if.wb1_addr_i  = 5'd2;
      sb_if.wb1_data_i  = 64'h2;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (sb_if.wb1_ready_o !== 1'b0 || waddr_o !== 5'd1) begin errors++; $display("[TB] FAIL starve_wait%0d got ready %0b addr %0d exp 0/1", c, sb_if.wb1_ready_o, waddr_o); end
         tick();
      end
      #1;
      checks++; if (sb_if.wb1_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL slow_wb1_ready got %0b exp 1", sb_if.wb1_ready_o); end
      checks++; if (sb_if.wb0_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL slow_wb0_ready got %0b exp 0", sb_if.wb0_ready_o); end
      checks++; if (we_o !== 1'b1 || waddr_o !== 5'd2 || wdata_o !== 64'h2) begin errors++; $display("[TB] FAIL slow_write got %0b/%0d/%0h exp 1/2/2", we_o, waddr_o, wdata_o); end
      tick();
      #1;
      checks++; if (sb_if.wb0_ready_o !== 1'b1 || sb_if.wb1_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL back_to_norm got %0b/%0b exp 1/0", sb_if.wb0_ready_o, sb_if.wb1_ready_o); end
      idle_inputs();
      tick();
   endtask

   // x0 as destination: no busy bit and no regfile write.
   task automatic test_x0();
      drive_long_issue(5'd0);
      tick();
      idle_inputs();
      #1;
      checks++; if (busy_o !== 32'd0) begin errors++; $display("[TB] FAIL x0_busy got %0h exp 0", busy_o); end
      sb_if.wb0_valid_i = 1'b1;
      sb_if.wb0_addr_i  = 5'd0;
      sb_if.wb0_data_i  = 64'hFF;
      #1;
      checks++; if (sb_if.wb0_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL x0_wb0_ready got %0b exp 1", sb_if.wb0_ready_o); end
      checks++; if (we_o !== 1'b0) begin errors++; $display("[TB] FAIL x0_we got %0b exp 0", we_o); end
      tick();
      idle_inputs();
      tick();
   endtask

   // Same-cycle set and clear of x9: set wins.
   task automatic test_set_clear();
      drive_long_issue(5'd9);
      sb_if.wb1_valid_i = 1'b1;
      sb_if.wb1_addr_i  = 5'd9;
      sb_if.wb1_data_i  = 64'h99;
      #1;
      checks++; if (sb_if.issue_ready_o !== 1'b1 || sb_if.wb1_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL setclr_ready got %0b/%0b exp 1/1", sb_if.issue_ready_o, sb_if.wb1_ready_o); end
      tick();
      idle_inputs();
      #1;
      checks++; if (busy_o !== 32'h0000_0200) begin errors++; $display("[TB] FAIL setclr_busy got %0h exp 200", busy_o); end
      sb_if.wb1_valid_i = 1'b1;
      sb_if.wb1_addr_i  = 5'd9;
      tick();
      idle_inputs();
      #1;
      checks++; if (busy_o !== 32'd0) begin errors++; $display("[TB] FAIL setclr_cleared got %0h exp 0", busy_o); end
   endtask

   // Back-to-back long issues to x4 and x6, then reset discards both.
   task automatic test_reset_mid();
      drive_long_issue(5'd4);
      tick();
      drive_long_issue(5'd6);
      tick();
      idle_inputs();
      #1;
      checks++; if (busy_o !== 32'h0000_0050 || busy_cnt_o !== 6'd2) begin errors++; $display("[TB] FAIL b2b_busy got %0h/%0d exp 50/2", busy_o, busy_cnt_o); end
      rst = 1'b1;
      sb_if.issue_valid_i = 1'b1;
      sb_if.wb0_valid_i   = 1'b1;
      sb_if.wb0_addr_i    = 5'd3;
      sb_if.wb1_valid_i   = 1'b1;
      sb_if.wb1_addr_i    = 5'd4;
      #1;
      checks++; if (sb_if.issue_ready_o !== 1'b0 || sb_if.wb0_ready_o !== 1'b0 || sb_if.wb1_ready_o !== 1'b0 || we_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_outputs got %0b%0b%0b%0b exp 0000", sb_if.issue_ready_o, sb_if.wb0_ready_o, sb_if.wb1_ready_o, we_o); end
      tick();
      #1;
      checks++; if (busy_o !== 32'd0 || busy_cnt_o !== 6'd0) begin errors++; $display("[TB] FAIL midrst_busy got %0h/%0d exp 0/0", busy_o, busy_cnt_o); end
      rst = 1'b0;
      idle_inputs();
      sb_if.issue_valid_i = 1'b1;
      sb_if.issue_re1_i   = 1'b1;
      sb_if.issue_rs1_i   = 5'd4;
      #1;
      checks++; if (sb_if.issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %0b exp 1", sb_if.issue_ready_o); end
      idle_inputs();
      tick();
   endtask

   initial begin
      $display("[TB] starting rf_scoreboard bench");
      test_reset();
      test_raw_hazard();
      test_wb_priority();
      test_starve();
      test_x0();
      test_set_clear();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
